i2s_tx_sample_buffer: RTL and testbench
=======================================

// Module: i2s_tx_sample_buffer
// PURPOSE
//  Single-bank sample buffer directly upstream of the I2S 24-bit transmitter.
//  A producer fills it with signed 24-bit mono PCM until DEPTH words are stored or
//  a write carries wr_last_i. It then pulses buffer_ready_o and serves words over a
//  ready/valid port whose data is valid in the same cycle as the consumer's ready.
//  When the buffer is drained it deasserts valid, so the transmitter idles at the
//  next WS edge, and the buffer reopens for filling.
// PARAMETERS
//  DATA_W  24    sample width (signed PCM)
//  DEPTH   1024  buffer capacity in samples (>=2)
//  ADDR_W  $clog2(DEPTH)  derived; width of pointers/count
// PORTS
//  clk_i           in   1        system clock (27 MHz)
//  rst_ni          in   1        asynchronous reset, active-low
//  wr_data_i       in   DATA_W   producer sample (signed)
//  wr_valid_i      in   1        producer sample valid
//  wr_last_i       in   1        qualifies wr_data_i: final sample of this buffer
//  wr_ready_o      out  1        buffer accepts writes (state FILL)
//  flush_i         in   1        sync discard: drop contents, return to FILL
//  ram_data_o      out  DATA_W   head sample to transmitter (signed)
//  ram_valid_o     out  1        head sample valid
//  ram_ready_i     in   1        transmitter request pulse; transfer = valid & ready
//  buffer_ready_o  out  1        one-cycle pulse: buffer loaded, first word valid
//  level_o         out  ADDR_W+1 samples stored and not yet consumed
//  busy_o          out  1        state != FILL
// BEHAVIOUR
//  Reset (async): state FILL, wr_ptr=rd_ptr=count=0, ram_data_o=0, ram_valid_o=0,
//   buffer_ready_o=0, wr_ready_o=1, level_o=0, busy_o=0.
//  States FILL, PRIME, SERVE, FETCH:
//  - FILL: wr_ready_o=1. Write accepted on wr_valid_i: mem[wr_ptr]<=wr_data_i,
//    wr_ptr++, count++. If the accepted write makes count==DEPTH or has
//    wr_last_i=1, the next state is PRIME. wr_last_i without wr_valid_i is ignored.
//  - PRIME: one cycle. Issue read rd_ptr=0. Next state is SERVE.
//  - SERVE: RAM output register drives ram_data_o. ram_valid_o=1.
//    buffer_ready_o=1 in the first SERVE cycle after PRIME only.
//    On transfer: rd_ptr++ and level_o--. If the transferred word was the last
//    (rd_ptr+1==count), ram_valid_o drops next cycle and the next state is FILL
//    (pointers and count cleared). Otherwise the next state is FETCH.
//  - FETCH: ram_valid_o=0 for exactly one cycle. Issue read rd_ptr. Next state is SERVE.
//  Latency: buffer_ready_o and ram_valid_o rise on the 2nd clock edge after the
//   committing write. After a transfer, the next word is valid 2 edges later.
//  ram_data_o is stable while ram_valid_o=1. The RAM output register updates
//   only on read enable.
//  ram_ready_i while ram_valid_o=0 is not a transfer and is ignored (no pointer
//   change, no error).
//  wr_valid_i outside FILL is not accepted (wr_ready_o=0). The producer must hold.
//  flush_i in any state: at the next edge, state FILL, pointers/count=0,
//   ram_valid_o=0, buffer_ready_o=0. flush_i takes priority over a same-cycle
//   write or transfer, and that write or transfer is lost.
//  Single-sample buffer (first write has wr_last_i=1): PRIME, then SERVE with one
//   word. Its transfer returns the block to FILL.
//  Arithmetic: pointers wrap never occurs (count<=DEPTH). level_o=count-rd_ptr.
//   Data passes through unmodified (no sign handling).
// STRUCTURE
//  Shared package i2s_pkg: i2s_buf_state_e {FILL,PRIME,SERVE,FETCH}, SAMPLE_W=24.
//  Sub-module sample_ram_sdp: simple dual-port, 1 write port, 1 read port.
//   Registered read, 1-cycle latency. Output register cleared by rst_ni.
//   Infers block RAM.
//  Top holds the FSM, pointers, count and handshake logic.
// TESTING (DEPTH=8 for sim)
//  1. Write 0x000001..0x000008 with no wr_last_i -> wr_ready_o falls after the
//     8th write. buffer_ready_o pulses once 2 edges later with ram_data_o=0x000001
//     and ram_valid_o=1.
//  2. Issue 8 single-cycle ready pulses spaced 5 clocks apart -> the consumer
//     receives 0x000001..0x000008 in order. Valid is low 1 cycle after each
//     transfer. After the 8th, ram_valid_o=0, wr_ready_o=1, level_o=0.
//  3. Write 3 samples with wr_last_i on the 3rd (0x800000, 0x7FFFFF, 0xFFFFFF) ->
//     level_o=3, and exactly 3 transfers return those values bit-exact.
//  4. Hold ram_ready_i=1 continuously through SERVE/FETCH -> exactly one transfer
//     per SERVE cycle, no duplicates and no skipped addresses.
//  5. flush_i asserted in SERVE with 5 words left -> next edge ram_valid_o=0,
//     level_o=0, wr_ready_o=1. A new fill of 2 samples is then served correctly.
//  6. Deassert rst_ni asynchronously mid-FETCH -> all outputs take their reset
//     values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types for the I2S transmit path: sample width and buffer FSM states.
package i2s_pkg;

    localparam int SAMPLE_W = 24;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PRIME = 2'd1,
        SERVE = 2'd2,
        FETCH = 2'd3
    } i2s_buf_state_e;

endpackage

// File: rtl/sample_ram_sdp.sv
// Simple dual-port sample RAM: one write port, one registered read port
// (1-cycle latency). The read register only moves when re_i is high, so the
// head sample stays put while the consumer is deciding.
module sample_ram_sdp #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage array, kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read output register, cleared by reset, updated only on read enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/i2s_tx_sample_buffer.sv
// Single-bank sample buffer feeding the I2S transmitter. Fills until full or a
// write marked last, then serves words one at a time; each served word costs a
// FETCH cycle because the RAM read is registered.
module i2s_tx_sample_buffer
    import i2s_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_valid_i,
    input  logic              wr_last_i,
    output logic              wr_ready_o,
    input  logic              flush_i,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_valid_o,
    input  logic              ram_ready_i,
    output logic              buffer_ready_o,
    output logic [ADDR_W:0]   level_o,
    output logic              busy_o
);

    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_LASTW = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADR_ONE   = ADDR_W'(1);

    i2s_buf_state_e    state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              first_q, first_d;

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;

    // State, pointers, count and first-SERVE marker.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            first_q  <= first_d;
        end
    end

    // Next-state and RAM control; flush overrides any same-cycle write or transfer.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        first_d   = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_raddr = rd_ptr_q[ADDR_W-1:0];

        if (flush_i) begin
            state_d  = FILL;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (wr_valid_i) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ADR_ONE;
                        count_d  = count_q + CNT_ONE;
                        if (wr_last_i || count_q == CNT_LASTW) begin
                            state_d = PRIME;
                        end
                    end
                end
                PRIME: begin
                    ram_re    = 1'b1;
                    ram_raddr = '0;
                    first_d   = 1'b1;
                    state_d   = SERVE;
                end
                SERVE: begin
                    if (ram_ready_i) begin
                        if (rd_ptr_q + CNT_ONE == count_q) begin
                            // Last word gone: reopen for filling.
                            state_d  = FILL;
                            wr_ptr_d = '0;
                            rd_ptr_d = '0;
                            count_d  = '0;
                        end else begin
                            rd_ptr_d = rd_ptr_q + CNT_ONE;
                            state_d  = FETCH;
                        end
                    end
                end
                FETCH: begin
                    ram_re  = 1'b1;
                    state_d = SERVE;
                end
                default: state_d = FILL;
            endcase
        end
    end

    sample_ram_sdp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data_i),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_data_o)
    );

    assign wr_ready_o     = (state_q == FILL);
    assign busy_o         = (state_q != FILL);
    assign ram_valid_o    = (state_q == SERVE);
    assign buffer_ready_o = (state_q == SERVE) && first_q;
    assign level_o        = count_q - rd_ptr_q;

endmodule

// File: tb/tb_i2s_tx_sample_buffer.sv
// Directed bench for the I2S sample buffer at DEPTH=8.
module tb_i2s_tx_sample_buffer;

    localparam int DW = 24;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] wr_data;
    logic          wr_valid, wr_last, wr_ready, flush;
    logic [DW-1:0] ram_data;
    logic          ram_valid, ram_ready, buf_rdy, busy;
    logic [3:0]    level;

    int n_chk  = 0;
    int n_pass = 0;

    i2s_tx_sample_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .wr_data_i      (wr_data),
        .wr_valid_i     (wr_valid),
        .wr_last_i      (wr_last),
        .wr_ready_o     (wr_ready),
        .flush_i        (flush),
        .ram_data_o     (ram_data),
        .ram_valid_o    (ram_valid),
        .ram_ready_i    (ram_ready),
        .buffer_ready_o (buf_rdy),
        .level_o        (level),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic last);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // Wait (bounded) for a valid head word, check it, take it with a 1-cycle pulse.
    task automatic pop(input string tag, input logic [DW-1:0] exp);
        for (int n = 0; n < 10 && !ram_valid; n++) tick();
        chk({tag, "_valid"}, 32'(ram_valid), 32'd1);
        chk({tag, "_data"}, 32'(ram_data), 32'(exp));
        ram_ready = 1'b1;
        tick();
        ram_ready = 1'b0;
    endtask

    logic [DW-1:0] got_q [$];

    initial begin
        rst_n = 1'b0; wr_data = '0; wr_valid = 1'b0; wr_last = 1'b0;
        flush = 1'b0; ram_ready = 1'b0;
        #12;
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_valid",    32'(ram_valid), 32'd0);
        chk("rst_data",     32'(ram_data), 32'd0);
        chk("rst_level",    32'(level), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_bufrdy",   32'(buf_rdy), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: fill to capacity without last
        for (int i = 0; i < DEPTH; i++) begin
            chk("t1_wr_ready_fill", 32'(wr_ready), 32'd1);
            push(DW'(i + 1), 1'b0);
        end
        chk("t1_wr_ready_full", 32'(wr_ready), 32'd0);
        chk("t1_busy",          32'(busy), 32'd1);
        chk("t1_prime_valid",   32'(ram_valid), 32'd0);
        chk("t1_prime_bufrdy",  32'(buf_rdy), 32'd0);
        tick();
        chk("t1_bufrdy",  32'(buf_rdy), 32'd1);
        chk("t1_valid",   32'(ram_valid), 32'd1);
        chk("t1_data",    32'(ram_data), 32'd1);
        chk("t1_level",   32'(level), 32'd8);
        tick();
        chk("t1_bufrdy_once", 32'(buf_rdy), 32'd0);
        chk("t1_data_hold",   32'(ram_data), 32'd1);

        // 2: eight spaced pulses; a ready during FETCH must be ignored
        for (int k = 0; k < DEPTH; k++) begin
            chk("t2_valid", 32'(ram_valid), 32'd1);
            chk("t2_data",  32'(ram_data), 32'(k + 1));
            ram_ready = 1'b1;
            tick();
            ram_ready = 1'b0;
            chk("t2_valid_low", 32'(ram_valid), 32'd0);
            chk("t2_level",     32'(level), 32'(DEPTH - 1 - k));
            for (int j = 0; j < 4; j++) begin
                ram_ready = (k == 2 && j == 0);
                tick();
            end
            ram_ready = 1'b0;
        end
        chk("t2_end_valid",    32'(ram_valid), 32'd0);
        chk("t2_end_wr_ready", 32'(wr_ready), 32'd1);
        chk("t2_end_level",    32'(level), 32'd0);

        // 3: short buffer with last, signed extremes
        push(24'h800000, 1'b0);
        push(24'h7FFFFF, 1'b0);
        push(24'hFFFFFF, 1'b1);
        chk("t3_level",     32'(level), 32'd3);
        chk("t3_wr_ready",  32'(wr_ready), 32'd0);
        tick();
        chk("t3_bufrdy",    32'(buf_rdy), 32'd1);
        pop("t3_w0", 24'h800000);
        pop("t3_w1", 24'h7FFFFF);
        pop("t3_w2", 24'hFFFFFF);
        chk("t3_wr_ready_end", 32'(wr_ready), 32'd1);
        chk("t3_level_end",    32'(level), 32'd0);

        // 4: ready held high through fill and serve
        ram_ready = 1'b1;
        push(24'h00000A, 1'b0);
        push(24'h00000B, 1'b0);
        push(24'h00000C, 1'b0);
        push(24'h00000D, 1'b1);
        for (int c = 0; c < 20; c++) begin
            if (ram_valid) got_q.push_back(ram_data);
            tick();
        end
        ram_ready = 1'b0;
        chk("t4_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            chk("t4_data", 32'(got_q[i]), 32'(24'h00000A + i));
        chk("t4_wr_ready", 32'(wr_ready), 32'd1);

        // 5: flush with 5 words left, then a fresh 2-word fill
        for (int i = 0; i < DEPTH; i++) push(DW'(24'h000100 + i), 1'b0);
        tick();
        pop("t5_p0", 24'h000100);
        pop("t5_p1", 24'h000101);
        pop("t5_p2", 24'h000102);
        tick();
        chk("t5_pre_valid", 32'(ram_valid), 32'd1);
        chk("t5_pre_level", 32'(level), 32'd5);
        flush = 1'b1;
        ram_ready = 1'b1;
        tick();
        flush = 1'b0;
        ram_ready = 1'b0;
        chk("t5_valid",    32'(ram_valid), 32'd0);
        chk("t5_level",    32'(level), 32'd0);
        chk("t5_wr_ready", 32'(wr_ready), 32'd1);
        chk("t5_busy",     32'(busy), 32'd0);
        push(24'h000055, 1'b0);
        push(24'h000066, 1'b1);
        tick();
        chk("t5_bufrdy", 32'(buf_rdy), 32'd1);
        pop("t5_n0", 24'h000055);
        pop("t5_n1", 24'h000066);
        chk("t5_end_wr_ready", 32'(wr_ready), 32'd1);

        // 6: asynchronous reset in the middle of FETCH
        push(24'h000011, 1'b0);
        push(24'h000022, 1'b0);
        push(24'h000033, 1'b1);
        tick();
        pop("t6_p0", 24'h000011);
        chk("t6_in_fetch", 32'(ram_valid), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_wr_ready", 32'(wr_ready), 32'd1);
        chk("t6_data",     32'(ram_data), 32'd0);
        chk("t6_level",    32'(level), 32'd0);
        chk("t6_busy",     32'(busy), 32'd0);
        chk("t6_bufrdy",   32'(buf_rdy), 32'd0);
        tick();
        chk("t6_valid",    32'(ram_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t6_post_wr_ready", 32'(wr_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
